// File: rtl/pcr_seq_pkg.sv
// Purpose: shared state encoding and default sizing for the PCR mix sequencer.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pcr_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SELECT,
        ST_DOSE,
        ST_MIX,
        ST_FLUSH,
        ST_DONE
    } state_t;

    localparam int DEF_N_CH      = 6;
    localparam int DEF_DOSE_W    = 16;
    localparam int DEF_MIX_W     = 16;
    localparam int DEF_FLUSH_CYC = 64;

endpackage

// File: rtl/dwell_counter.sv
// Purpose: down-counter timing one phase; load with a length, expire marks its last cycle.
// Latency: expire is high in the cycle after load when len=1, len cycles after load otherwise.
// Backpressure: none; load always wins and restarts the count.
//
// Ports:
//   clk, rst_n  clock and asynchronous active-low reset
//   load        restart the count with len (len must be >= 1)
//   len         phase length in cycles
//   expire      counter at zero: current cycle is the last one of the phase
module dwell_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] len,
    output logic         expire
);

    logic [W-1:0] cnt;

    // Loading len-1 and stopping at zero means a full-scale len never wraps.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= len - W'(1);
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign expire = (cnt == '0);

endmodule

// File: rtl/pcr_mix_sequencer.sv
// Purpose: sequence reagent inlet doses, mixer dwells and a final output flush for a PCR mix chain.
// Latency: busy one cycle after an accepted start; outputs are registered and change on the clock edge.
// Backpressure: none; start is only honoured in IDLE, abort forces IDLE from any state.
//
// Ports:
//   clk, rst_n              clock and asynchronous active-low reset
//   start, abort            run request (IDLE only) and run abandon (any state, beats start)
//   ch_mask, mix_cycles     per-run channel enable and mixer dwell, latched at start
//   cfg_we/cfg_ch/cfg_dose  dose table write port; cfg_err pulses when a write is rejected
//   valve_open, mixer_en,   actuator drives, at most one asserted in any cycle
//   out_valve
//   cur_ch                  channel dosing or mixing, 0 otherwise
//   busy, done              run in progress; one-cycle completion pulse (never on abort)
module pcr_mix_sequencer
    import pcr_seq_pkg::*;
#(
    parameter int N_CH      = DEF_N_CH,
    parameter int DOSE_W    = DEF_DOSE_W,
    parameter int MIX_W     = DEF_MIX_W,
    parameter int FLUSH_CYC = DEF_FLUSH_CYC
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    abort,
    input  logic [N_CH-1:0]         ch_mask,
    input  logic [MIX_W-1:0]        mix_cycles,
    input  logic                    cfg_we,
    input  logic [$clog2(N_CH)-1:0] cfg_ch,
    input  logic [DOSE_W-1:0]       cfg_dose,
    output logic                    cfg_err,
    output logic [N_CH-1:0]         valve_open,
    output logic                    mixer_en,
    output logic                    out_valve,
    output logic [$clog2(N_CH)-1:0] cur_ch,
    output logic                    busy,
    output logic                    done
);

    localparam int CH_W  = $clog2(N_CH);
    localparam int PTR_W = $clog2(N_CH + 1);
    localparam int FL_W  = $clog2(FLUSH_CYC + 1);

    state_t            state;
    logic [N_CH-1:0]   mask_lat;
    logic [MIX_W-1:0]  mix_lat;
    logic [PTR_W-1:0]  ptr;
    logic [DOSE_W-1:0] dose_tab [N_CH];

    // Next eligible channel at or above ptr; lowest index wins.
    logic              found;
    logic [CH_W-1:0]   sel_idx;
    logic [PTR_W-1:0]  sel_next;
    logic [DOSE_W-1:0] sel_dose;

    always_comb begin
        found    = 1'b0;
        sel_idx  = '0;
        sel_next = '0;
        sel_dose = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (!found && mask_lat[i] && (dose_tab[i] != '0) && (i >= int'(ptr))) begin
                found    = 1'b1;
                sel_idx  = CH_W'(i);
                sel_next = PTR_W'(i + 1);
                sel_dose = dose_tab[i];
            end
        end
    end

    logic dose_load, mix_load, flush_load;
    logic dose_exp, mix_exp, flush_exp;

    // Counters are loaded on the edge that enters their phase, so their
    // expire flag lines up with the last cycle the phase output is high.
    assign dose_load  = (state == ST_SELECT) && found;
    assign flush_load = (state == ST_SELECT) && !found;
    assign mix_load   = (state == ST_DOSE) && dose_exp && (mix_lat != '0);

    dwell_counter #(.W(DOSE_W)) u_dose_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (dose_load),
        .len    (sel_dose),
        .expire (dose_exp)
    );

    dwell_counter #(.W(MIX_W)) u_mix_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (mix_load),
        .len    (mix_lat),
        .expire (mix_exp)
    );

    dwell_counter #(.W(FL_W)) u_flush_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (flush_load),
        .len    (FL_W'(FLUSH_CYC)),
        .expire (flush_exp)
    );

    // Dose table: writable only while no run is using it.
    logic cfg_open, cfg_ok;
    assign cfg_open = (state == ST_IDLE) || (state == ST_DONE);
    assign cfg_ok   = cfg_we && cfg_open && (int'(cfg_ch) < N_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_CH; i++) begin
                dose_tab[i] <= '0;
            end
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_we && !cfg_ok;
            for (int i = 0; i < N_CH; i++) begin
                if (cfg_ok && (int'(cfg_ch) == i)) begin
                    dose_tab[i] <= cfg_dose;
                end
            end
        end
    end

    // Sequencer FSM. Pulse-style outputs default low each cycle and are
    // re-asserted only while their phase continues.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            mask_lat   <= '0;
            mix_lat    <= '0;
            ptr        <= '0;
            valve_open <= '0;
            mixer_en   <= 1'b0;
            out_valve  <= 1'b0;
            cur_ch     <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            valve_open <= '0;
            mixer_en   <= 1'b0;
            out_valve  <= 1'b0;
            done       <= 1'b0;
            if (abort) begin
                state  <= ST_IDLE;
                busy   <= 1'b0;
                cur_ch <= '0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start) begin
                            mask_lat <= ch_mask;
                            mix_lat  <= mix_cycles;
                            ptr      <= '0;
                            busy     <= 1'b1;
                            state    <= ST_SELECT;
                        end
                    end
                    ST_SELECT: begin
                        if (found) begin
                            valve_open <= N_CH'(1) << sel_idx;
                            cur_ch     <= sel_idx;
                            ptr        <= sel_next;
                            state      <= ST_DOSE;
                        end else begin
                            out_valve <= 1'b1;
                            state     <= ST_FLUSH;
                        end
                    end
                    ST_DOSE: begin
                        if (dose_exp) begin
                            if (mix_lat != '0) begin
                                mixer_en <= 1'b1;
                                state    <= ST_MIX;
                            end else begin
                                cur_ch <= '0;
                                state  <= ST_SELECT;
                            end
                        end else begin
                            valve_open <= valve_open;
                        end
                    end
                    ST_MIX: begin
                        if (mix_exp) begin
                            cur_ch <= '0;
                            state  <= ST_SELECT;
                        end else begin
                            mixer_en <= 1'b1;
                        end
                    end
                    ST_FLUSH: begin
                        if (flush_exp) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            out_valve <= 1'b1;
                        end
                    end
                    ST_DONE: begin
                        state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule
